// File: rtl/key_evt_pkg.sv
// Shared types and event codes for the key gesture classifier and its consumers.
package key_evt_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS1   = 3'd1,
    GAP      = 3'd2,
    WAIT_REL = 3'd3,
    HOLD     = 3'd4
  } state_t;

  localparam logic [1:0] EVT_CLICK  = 2'd0;
  localparam logic [1:0] EVT_DOUBLE = 2'd1;
  localparam logic [1:0] EVT_LONG   = 2'd2;
  localparam logic [1:0] EVT_REPEAT = 2'd3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every millisecond.
module ms_tick_gen #(
  parameter int unsigned CLK_FREQ = 65_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned DIV = CLK_FREQ / 1000;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/key_event_fsm.sv
// Classifies debounced key gestures into click / double / long / repeat events
// and hands them out one at a time through a valid/ready holding register.
module key_event_fsm
  import key_evt_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 65_000_000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DCLICK_MS = 300,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_lvl,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_ovf,
  input  logic       ovf_clr,
  output logic       busy
);

  localparam int unsigned MAX_MS = max3(LONG_MS, DCLICK_MS, REPEAT_MS);
  localparam int unsigned MSW    = $clog2(MAX_MS + 1);
  localparam logic [MSW-1:0] LONG_C   = MSW'(LONG_MS);
  localparam logic [MSW-1:0] DCLICK_C = MSW'(DCLICK_MS);
  localparam logic [MSW-1:0] REPEAT_C = MSW'(REPEAT_MS);

  state_t         r_state;
  state_t         w_stateNext;
  logic [MSW-1:0] r_ms;
  logic           w_tick;
  logic           w_emit;
  logic [1:0]     w_emitCode;
  logic           w_clrMs;
  logic           w_accept;
  logic           r_valid;
  logic [1:0]     r_code;
  logic           r_ovf;
  logic           r_busy;

  ms_tick_gen #(
    .CLK_FREQ(CLK_FREQ)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (w_tick)
  );

  // Key level changes are tested before timeouts so an edge always wins a tie.
  always_comb begin
    w_stateNext = r_state;
    w_emit      = 1'b0;
    w_emitCode  = EVT_CLICK;
    w_clrMs     = 1'b0;
    case (r_state)
      IDLE: begin
        if (key_lvl) w_stateNext = PRESS1;
      end
      PRESS1: begin
        if (!key_lvl) begin
          w_stateNext = GAP;
        end else if (r_ms == LONG_C) begin
          w_emit      = 1'b1;
          w_emitCode  = EVT_LONG;
          w_stateNext = HOLD;
        end
      end
      GAP: begin
        if (key_lvl) begin
          w_emit      = 1'b1;
          w_emitCode  = EVT_DOUBLE;
          w_stateNext = WAIT_REL;
        end else if (r_ms == DCLICK_C) begin
          w_emit      = 1'b1;
          w_emitCode  = EVT_CLICK;
          w_stateNext = IDLE;
        end
      end
      WAIT_REL: begin
        if (!key_lvl) w_stateNext = IDLE;
      end
      HOLD: begin
        if (!key_lvl) begin
          w_stateNext = IDLE;
        end else if (r_ms == REPEAT_C) begin
          w_emit     = 1'b1;
          w_emitCode = EVT_REPEAT;
          w_clrMs    = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_busy  <= (w_stateNext != IDLE);
    end
  end

  // Interval counter restarts on every state change so each state times itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ms <= '0;
    end else if ((w_stateNext != r_state) || w_clrMs) begin
      r_ms <= '0;
    end else if (w_tick && (r_ms != '1)) begin
      r_ms <= r_ms + 1'b1;
    end
  end

  assign w_accept = r_valid & evt_ready;

  // An event arriving while the holder is full and not being drained is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_code  <= EVT_CLICK;
      r_ovf   <= 1'b0;
    end else begin
      if (w_emit && (!r_valid || w_accept)) begin
        r_valid <= 1'b1;
        r_code  <= w_emitCode;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_emit && r_valid && !evt_ready) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign evt_valid = r_valid;
  assign evt_code  = r_code;
  assign evt_ovf   = r_ovf;
  assign busy      = r_busy;

endmodule
